heartbeat_scan: RTL
===================

// Module: heartbeat_scan
// PURPOSE
//  Parametrised heartbeat animator with a built-in time-multiplexed seven-segment scanner.
//  Draws a two-bar "heartbeat" on the two centre digits of an N-digit display.
//  Adds a stop mode, a two-phase beat and a lub-dub (six-step) beat, plus a display enable.
//  Sits directly between the board clock/reset and the sseg/an display pins.
// PARAMETERS
//  N_DIGITS  8          number of display digits; even, 2..16
//  BEAT_DIV  1_388_889  clk cycles per animation step (100 MHz / 72 Hz)
//  SCAN_DIV  50_000     clk cycles each digit is lit per scan slot
// PORTS
//  clk    in   1         system clock, rising edge
//  rst    in   1         asynchronous, active-high reset
//  en     in   1         1 = animate and display; 0 = blank display and freeze animation
//  mode   in   2         00 stop (hold), 01 two-phase beat, 10 lub-dub beat, 11 same as 01
//  sseg   out  8         active-low segments {dp,g,f,e,d,c,b,a}
//  an     out  N_DIGITS  active-low one-hot digit enable; an[0] = rightmost digit
//  phase  out  2         current pattern: 00 WIDE, 01 NARROW, 10 BLANK
// BEHAVIOUR
//  Reset (async, immediate): an = all 1s, sseg = 8'hFF, phase = 00.
//   Internal state after reset: beat count = 0, scan count = 0, digit index = 0, step = 0.
//  Prescaler:
//   - Counts 0..BEAT_DIV-1 only while en = 1; holds its value while en = 0.
//   - beat_tick is asserted for 1 cycle when count = BEAT_DIV-1; count then wraps to 0.
//  Step register (0..5) updates only on beat_tick:
//   - mode 00: hold current step.
//   - mode 01/11: step' = (step == 0) ? 1 : 0. Any step other than 0 goes to 0.
//   - mode 10: step' = (step == 5) ? 0 : step + 1.
//   - mode is sampled only on the tick cycle; a change between ticks has no effect until the next tick.
//  Phase decode (combinational from step; the phase port is registered):
//   - steps 0, 2 -> WIDE
//   - steps 1, 3 -> NARROW
//   - steps 4, 5 -> BLANK
//  Scanner (runs regardless of en):
//   - Scan count runs 0..SCAN_DIV-1.
//   - At SCAN_DIV-1 the digit index advances 0..N_DIGITS-1 and wraps to 0.
//  Digit content (L = N_DIGITS/2, R = N_DIGITS/2-1):
//   - WIDE: digit L = 8'hCF (left bar e,f); digit R = 8'hF9 (right bar b,c).
//   - NARROW: digit L = 8'hF9; digit R = 8'hCF.
//   - BLANK, or any other digit: 8'hFF.
//  Output registers:
//   - an = ~(1 << digit index) when en = 1; all 1s when en = 0.
//   - sseg = content of the selected digit when en = 1; 8'hFF when en = 0.
//   - Latency: an/sseg/phase change 1 cycle after the digit index or step changes.
//  Boundary cases:
//   - beat_tick and a digit-index wrap on the same cycle are independent; both take effect.
//   - en falling on a tick cycle: that tick still advances step; later ticks are suppressed.
//   - rst asserted mid-scan or mid-beat: all state returns to reset values with no clock edge needed.
// TESTING  (N_DIGITS=4, BEAT_DIV=10, SCAN_DIV=2)
//  1 Reset, then release with en=1, mode=01:
//    -> while rst is high, an=4'hF and sseg=8'hFF;
//    -> after release an cycles E,D,B,7, each held 2 cycles.
//  2 mode=01 -> phase toggles WIDE/NARROW every 10 cycles;
//    -> WIDE: an=B gives sseg CF, an=D gives F9; NARROW swaps them;
//    -> digits 0 and 3 always show FF.
//  3 mode=10 -> phase sequence W,N,W,N,B,B repeats every 60 cycles;
//    -> during BLANK, an keeps scanning and sseg stays FF.
//  4 mode 10 up to step 3, then mode=00 for 50 cycles -> phase held NARROW;
//    -> on return to mode 10 the next tick gives step 4 (BLANK).
//  5 en=0 for 25 cycles at prescaler count 4 -> an=F, sseg=FF, step frozen;
//    -> after en=1 the next tick comes 6 cycles later.
//  6 rst pulse asserted between clock edges mid-scan -> an=F, sseg=FF, phase=00 immediately;
//    -> scan restarts at digit 0 after release.

Source files
------------

// File: rtl/heartbeat_scan.sv
// ---------------------------------------------------------------------------
// heartbeat_scan
//
// Heartbeat animator with a built-in time-multiplexed seven-segment scanner.
// A two-bar "heartbeat" is drawn on the two centre digits of an N-digit
// display. It alternates between a wide pair of bars (outer edges lit) and a
// narrow pair (inner edges lit), with an optional blank phase in lub-dub mode.
//
// Parameters
//   N_DIGITS  number of display digits (even, 2..16)
//   BEAT_DIV  clk cycles per animation step
//   SCAN_DIV  clk cycles each digit stays lit per scan slot
//
// Ports
//   clk    in   1         system clock, rising edge
//   rst    in   1         asynchronous active-high reset
//   en     in   1         1 = animate and display, 0 = blank display and freeze
//   mode   in   2         00 stop, 01/11 two-phase beat, 10 lub-dub (six steps)
//   sseg   out  8         active-low segments {dp,g,f,e,d,c,b,a}
//   an     out  N_DIGITS  active-low one-hot digit enable, an[0] = rightmost
//   phase  out  2         current pattern: 00 WIDE, 01 NARROW, 10 BLANK
// ---------------------------------------------------------------------------
module heartbeat_scan #(
  parameter int N_DIGITS = 8,
  parameter int BEAT_DIV = 1_388_889,
  parameter int SCAN_DIV = 50_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [1:0]          mode,
  output logic [7:0]          sseg,
  output logic [N_DIGITS-1:0] an,
  output logic [1:0]          phase
);

  // Counter widths; a divider of 1 still needs a 1-bit counter.
  localparam int BW = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [BW-1:0] BEAT_LAST  = BW'(BEAT_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] DIGIT_LAST = IW'(N_DIGITS - 1);

  // Centre digit positions: L is the left of the pair, R the right.
  localparam int DIG_L = N_DIGITS / 2;
  localparam int DIG_R = N_DIGITS / 2 - 1;

  // Pattern encodings (also the phase port values).
  localparam logic [1:0] PH_WIDE   = 2'b00;
  localparam logic [1:0] PH_NARROW = 2'b01;
  localparam logic [1:0] PH_BLANK  = 2'b10;

  // Mode encodings.
  localparam logic [1:0] MODE_STOP   = 2'b00;
  localparam logic [1:0] MODE_LUBDUB = 2'b10;

  localparam logic [2:0] STEP_LAST = 3'd5;

  // Segment glyphs (active low).
  localparam logic [7:0] SEG_LEFT_BAR  = 8'hCF;  // segments e,f
  localparam logic [7:0] SEG_RIGHT_BAR = 8'hF9;  // segments b,c
  localparam logic [7:0] SEG_OFF       = 8'hFF;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [BW-1:0]       beat_cnt_reg,  beat_cnt_next;
  logic [SW-1:0]       scan_cnt_reg,  scan_cnt_next;
  logic [IW-1:0]       digit_idx_reg, digit_idx_next;
  logic [2:0]          step_reg,      step_next;
  logic [1:0]          phase_reg,     phase_next;
  logic [7:0]          sseg_reg,      sseg_next;
  logic [N_DIGITS-1:0] an_reg,        an_next;

  logic                beat_tick;
  logic                scan_wrap;

  // -------------------------------------------------------------------------
  // Beat prescaler: advances only while enabled, holds its count otherwise.
  // Gating the tick with en keeps a count parked at BEAT_LAST from firing
  // repeatedly while the display is disabled.
  // -------------------------------------------------------------------------
  assign beat_tick = en && (beat_cnt_reg == BEAT_LAST);

  always_comb begin
    beat_cnt_next = beat_cnt_reg;
    if (en) begin
      if (beat_cnt_reg == BEAT_LAST) begin
        beat_cnt_next = '0;
      end else begin
        beat_cnt_next = beat_cnt_reg + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Animation step. The mode input only matters on the tick cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    step_next = step_reg;
    if (beat_tick) begin
      case (mode)
        MODE_STOP: begin
          step_next = step_reg;
        end
        MODE_LUBDUB: begin
          step_next = (step_reg == STEP_LAST) ? 3'd0 : step_reg + 3'd1;
        end
        default: begin
          // Two-phase beat: anything left over from lub-dub collapses to 0.
          step_next = (step_reg == 3'd0) ? 3'd1 : 3'd0;
        end
      endcase
    end
  end

  // Steps 0,2 wide; 1,3 narrow; 4,5 blank.
  always_comb begin
    case (step_reg)
      3'd0, 3'd2: phase_next = PH_WIDE;
      3'd1, 3'd3: phase_next = PH_NARROW;
      default:    phase_next = PH_BLANK;
    endcase
  end

  // -------------------------------------------------------------------------
  // Digit scanner: free-running, independent of en and of the beat.
  // -------------------------------------------------------------------------
  assign scan_wrap = (scan_cnt_reg == SCAN_LAST);

  always_comb begin
    scan_cnt_next  = scan_wrap ? '0 : scan_cnt_reg + 1'b1;
    digit_idx_next = digit_idx_reg;
    if (scan_wrap) begin
      digit_idx_next = (digit_idx_reg == DIGIT_LAST) ? '0 : digit_idx_reg + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Per-digit content and one-hot anode decode. The content is taken from
  // the live step so sseg and phase update on the same clock.
  // -------------------------------------------------------------------------
  logic [7:0]          left_seg;
  logic [7:0]          right_seg;
  logic [7:0]          digit_seg [N_DIGITS];
  logic [N_DIGITS-1:0] an_onehot;

  always_comb begin
    case (phase_next)
      PH_WIDE: begin
        left_seg  = SEG_LEFT_BAR;
        right_seg = SEG_RIGHT_BAR;
      end
      PH_NARROW: begin
        left_seg  = SEG_RIGHT_BAR;
        right_seg = SEG_LEFT_BAR;
      end
      default: begin
        left_seg  = SEG_OFF;
        right_seg = SEG_OFF;
      end
    endcase
  end

  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
    if (gi == DIG_L) begin : g_left
      assign digit_seg[gi] = left_seg;
    end else if (gi == DIG_R) begin : g_right
      assign digit_seg[gi] = right_seg;
    end else begin : g_off
      assign digit_seg[gi] = SEG_OFF;
    end
    assign an_onehot[gi] = (digit_idx_reg == IW'(gi));
  end

  always_comb begin
    an_next   = '1;
    sseg_next = SEG_OFF;
    if (en) begin
      an_next   = ~an_onehot;
      sseg_next = digit_seg[digit_idx_reg];
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_reg  <= '0;
      scan_cnt_reg  <= '0;
      digit_idx_reg <= '0;
      step_reg      <= 3'd0;
      phase_reg     <= PH_WIDE;
      sseg_reg      <= SEG_OFF;
      an_reg        <= '1;
    end else begin
      beat_cnt_reg  <= beat_cnt_next;
      scan_cnt_reg  <= scan_cnt_next;
      digit_idx_reg <= digit_idx_next;
      step_reg      <= step_next;
      phase_reg     <= phase_next;
      sseg_reg      <= sseg_next;
      an_reg        <= an_next;
    end
  end

  assign sseg  = sseg_reg;
  assign an    = an_reg;
  assign phase = phase_reg;

endmodule
